// File: rtl/raster_pkg.sv
// raster_pkg: definitions shared by the rasterizer command path.
// Contents:
//   - opcode values,
//   - bit positions of the fields inside a protocol byte,
//   - the command_encoder state encoding,
//   - helpers that build the header byte and the Y byte.
// Byte layout: bit 7 is the start bit, bits 6:5 hold the opcode and
// bits 4:2 hold an X or Y coordinate.
package raster_pkg;

  localparam logic [1:0] CMD_LINE  = 2'd0;
  localparam logic [1:0] CMD_RECT  = 2'd1;
  localparam logic [1:0] CMD_PIXEL = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  localparam int START_BIT = 7;
  localparam int CMD_MSB   = 6;
  localparam int CMD_LSB   = 5;
  localparam int XY_MSB    = 4;
  localparam int XY_LSB    = 2;

  // Width of one queued command: {cmd, x1, y1}.
  localparam int CMD_W = 8;

  typedef enum logic [1:0] {
    ENC_IDLE = 2'd0,
    ENC_HDR  = 2'd1,
    ENC_YB   = 2'd2,
    ENC_GAP  = 2'd3
  } enc_state_e;

  // Header byte: start bit, opcode, X coordinate.
  function automatic logic [7:0] hdr_byte(input logic [1:0] c, input logic [2:0] x);
    logic [7:0] b;
    b                  = 8'h00;
    b[START_BIT]       = 1'b1;
    b[CMD_MSB:CMD_LSB] = c;
    b[XY_MSB:XY_LSB]   = x;
    return b;
  endfunction

  // Y byte: start bit clear, so the receiver never takes it for a header.
  function automatic logic [7:0] y_byte(input logic [2:0] y);
    logic [7:0] b;
    b                = 8'h00;
    b[XY_MSB:XY_LSB] = y;
    return b;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous show-ahead FIFO that holds queued encoder commands.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset. Reset empties
//               the FIFO.
//   push        writes wr_data. The write is ignored while full.
//   wr_data     entry to write.
//   pop         drops the head entry. The pop is ignored while empty.
//   rd_data     head entry. Valid whenever empty is low.
//   full        occupancy equals DEPTH.
//   empty       occupancy is zero.
// DEPTH must be a power of two, so the pointers wrap by overflowing.
module cmd_fifo
  import raster_pkg::*;
#(
  parameter int WIDTH = CMD_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r];

  // Storage array. Reset is not needed because the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy. A push and a pop on the same edge leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/command_encoder.sv
// command_encoder: host-side transmitter for the rasterizer command byte protocol.
// Each accepted command {cmd, x1, y1} is sent as a frame:
//   1. a header byte,
//   2. a Y byte,
//   3. GAP_CYCLES idle bytes of 0x00.
// The bus reads 0x00 whenever no frame is in flight.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset. Reset
//                        aborts any frame at once.
//   cmd_valid/cmd_ready  command handshake. A command is accepted when
//                        both are high at a rising edge.
//   cmd, x1, y1          opcode and coordinates, sampled on the
//                        accepting edge.
//   byte_out             protocol byte, to the receiver's ui_in.
//   byte_valid           high while byte_out carries a header byte or a
//                        Y byte.
//   busy                 high while a frame is in flight or queued
//                        commands remain.
// Build option CMD_ENC_FIFO_EN:
//   defined:   a FIFO_DEPTH-entry queue (cmd_fifo) buffers commands, and
//              cmd_ready = !full.
//   undefined: there is no queue. A command is accepted only when the
//              encoder can start its header on that same edge.
module command_encoder
  import raster_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [2:0] x1,
  input  logic [2:0] y1,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       busy
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  enc_state_e       state_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [2:0]       y_hold_r;
  logic [7:0]       byte_r;
  logic             byte_valid_r;

  logic             slot_free_s;
  logic             src_avail_s;
  logic             take_s;
  logic [1:0]       src_cmd_s;
  logic [2:0]       src_x_s;
  logic [2:0]       src_y_s;

  // A header can start only from IDLE, or on the last gap byte of the previous frame.
  assign slot_free_s = (state_r == ENC_IDLE) ||
                       ((state_r == ENC_GAP) && (gap_cnt_r == GAP_W'(0)));

`ifdef CMD_ENC_FIFO_EN
  logic [CMD_W-1:0] fifo_rd_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_valid),
    .wr_data ({cmd, x1, y1}),
    .pop     (take_s),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // The FSM reads only the queue head. A fresh push is seen one edge later, so there is no bypass.
  assign cmd_ready                      = !fifo_full_s;
  assign src_avail_s                    = !fifo_empty_s;
  assign {src_cmd_s, src_x_s, src_y_s}  = fifo_rd_s;
  assign busy                           = (state_r != ENC_IDLE) || !fifo_empty_s;
`else
  // No queue: the handshake edge is the header-load edge.
  assign cmd_ready   = slot_free_s;
  assign src_avail_s = cmd_valid;
  assign src_cmd_s   = cmd;
  assign src_x_s     = x1;
  assign src_y_s     = y1;
  assign busy        = (state_r != ENC_IDLE);
`endif

  assign take_s     = slot_free_s && src_avail_s;
  assign byte_out   = byte_r;
  assign byte_valid = byte_valid_r;

  // Frame sequencer. The bus byte and byte_valid are registered together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ENC_IDLE;
      gap_cnt_r    <= GAP_W'(0);
      y_hold_r     <= 3'd0;
      byte_r       <= 8'h00;
      byte_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ENC_IDLE: begin
          if (take_s) begin
            state_r      <= ENC_HDR;
            y_hold_r     <= src_y_s;
            byte_r       <= hdr_byte(src_cmd_s, src_x_s);
            byte_valid_r <= 1'b1;
          end else begin
            byte_r       <= 8'h00;
            byte_valid_r <= 1'b0;
          end
        end
        ENC_HDR: begin
          state_r      <= ENC_YB;
          byte_r       <= y_byte(y_hold_r);
          byte_valid_r <= 1'b1;
        end
        ENC_YB: begin
          state_r      <= ENC_GAP;
          gap_cnt_r    <= GAP_W'(GAP_CYCLES - 1);
          byte_r       <= 8'h00;
          byte_valid_r <= 1'b0;
        end
        ENC_GAP: begin
          if (gap_cnt_r != GAP_W'(0)) begin
            gap_cnt_r    <= gap_cnt_r - GAP_W'(1);
            byte_r       <= 8'h00;
            byte_valid_r <= 1'b0;
          end else if (take_s) begin
            // A back-to-back frame follows the last gap byte with no idle cycle.
            state_r      <= ENC_HDR;
            y_hold_r     <= src_y_s;
            byte_r       <= hdr_byte(src_cmd_s, src_x_s);
            byte_valid_r <= 1'b1;
          end else begin
            state_r      <= ENC_IDLE;
            byte_r       <= 8'h00;
            byte_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ENC_IDLE;
          gap_cnt_r    <= GAP_W'(0);
          byte_r       <= 8'h00;
          byte_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_command_encoder.sv
`timescale 1ns/1ps
module tb_command_encoder;

`ifdef CMD_ENC_FIFO_EN
  localparam int LAT   = 2;
  localparam int N_RST = 3;
`else
  localparam int LAT   = 1;
  localparam int N_RST = 1;
`endif
  localparam int GAP1 = 1;

  typedef struct {
    logic [1:0] c;
    logic [2:0] x;
    logic [2:0] y;
    logic [7:0] hdr;
    logic [7:0] yb;
  } vec_t;

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] yb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [2:0] x1 = 3'd0;
  logic [2:0] y1 = 3'd0;
  logic       cmd_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       busy;

  logic       cmd_valid2 = 1'b0;
  logic [1:0] cmd2 = 2'd0;
  logic [2:0] x2 = 3'd0;
  logic [2:0] y2 = 3'd0;
  logic       cmd_ready2;
  logic [7:0] byte_out2;
  logic       byte_valid2;
  logic       busy2;

  int   tests_run = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   gap_seen = 100;
  logic mon_en = 1'b0;
  logic phase_y = 1'b0;
  logic [7:0] exp_y = 8'h00;
  logic saw_not_ready = 1'b0;

  exp_t exp_q[$];
  int   hdr_q[$];
  vec_t vecs[8];

  command_encoder #(.FIFO_DEPTH(4), .GAP_CYCLES(GAP1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .x1(x1), .y1(y1), .byte_out(byte_out), .byte_valid(byte_valid), .busy(busy)
  );

  command_encoder #(.FIFO_DEPTH(4), .GAP_CYCLES(3)) dut_gap3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd(cmd2), .x1(x2), .y1(y2), .byte_out(byte_out2), .byte_valid(byte_valid2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name);
    tests_run++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  // Called at a negedge; holds cmd_valid until accepted and records the expectation.
  task automatic send(input vec_t v);
    int   t;
    exp_t e;
    t = 0;
    cmd_valid = 1'b1; cmd = v.c; x1 = v.x; y1 = v.y;
    while (!cmd_ready && t < 50) begin
      saw_not_ready = 1'b1;
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      fail_msg("accept_timeout");
    end else begin
      last_acc = cyc + 1;
      e.hdr = v.hdr;
      e.yb  = v.yb;
      exp_q.push_back(e);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send2(input logic [1:0] c, input logic [2:0] x, input logic [2:0] y);
    int t;
    t = 0;
    cmd_valid2 = 1'b1; cmd2 = c; x2 = x; y2 = y;
    while (!cmd_ready2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready2) fail_msg("gap3_accept_timeout");
    else @(negedge clk);
    cmd_valid2 = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy || phase_y) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail_msg(name);
    else chk(name, {6'd0, busy, byte_valid, byte_out}, 16'h0000);
  endtask

  // Monitor: every header must match the scoreboard head, then its Y byte, then idle bytes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (phase_y) begin
          chk("y_byte", {7'd0, byte_valid, byte_out}, {7'd0, 1'b1, exp_y});
          phase_y  = 1'b0;
          gap_seen = 0;
        end else if (byte_valid && byte_out[7]) begin
          chk("gap_len", {15'd0, (gap_seen >= GAP1)}, 16'h0001);
          if (exp_q.size() == 0) begin
            fail_msg("unexpected_header");
          end else begin
            e = exp_q.pop_front();
            chk("header", {8'd0, byte_out}, {8'd0, e.hdr});
            exp_y   = e.yb;
            phase_y = 1'b1;
            hdr_q.push_back(cyc);
          end
        end else begin
          chk("idle_byte", {7'd0, byte_valid, byte_out}, 16'h0000);
          gap_seen++;
        end
        if (byte_valid) chk("busy_in_frame", {15'd0, busy}, 16'h0001);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g_b[12];
    logic       g_v[12];
    vec_t       r;
    int         t;

    vecs[0] = '{2'd2, 3'd5, 3'd3, 8'hD4, 8'h0C};
    vecs[1] = '{2'd0, 3'd0, 3'd0, 8'h80, 8'h00};
    vecs[2] = '{2'd1, 3'd7, 3'd7, 8'hBC, 8'h1C};
    vecs[3] = '{2'd3, 3'd2, 3'd5, 8'hE8, 8'h14};
    vecs[4] = '{2'd2, 3'd4, 3'd1, 8'hD0, 8'h04};
    vecs[5] = '{2'd3, 3'd7, 3'd0, 8'hFC, 8'h00};
    vecs[6] = '{2'd0, 3'd1, 3'd6, 8'h84, 8'h18};
    vecs[7] = '{2'd1, 3'd3, 3'd2, 8'hAC, 8'h08};

    g_b = '{8'hD4, 8'h0C, 8'h00, 8'h00, 8'h00, 8'hBC, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    g_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_state", {4'd0, cmd_ready, busy, byte_valid, byte_out, 1'b0}, {4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset", {4'd0, cmd_ready, busy, byte_valid, byte_out, 1'b0}, {4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    mon_en = 1'b1;

    // Single command into an idle encoder
    hdr_q.delete();
    send(vecs[0]);
    drain("single_drain");
    if (hdr_q.size() == 1) chk("latency", 16'(hdr_q[0] - last_acc + 1), 16'(LAT));
    else fail_msg("single_header_count");

    // Four back-to-back commands: frame period 2 + GAP
    hdr_q.delete();
    for (int i = 1; i <= 4; i++) send(vecs[i]);
    drain("b2b_drain");
    chk("b2b_count", 16'(hdr_q.size()), 16'd4);
    for (int i = 1; i < hdr_q.size(); i++) chk("frame_period", 16'(hdr_q[i] - hdr_q[i-1]), 16'(2 + GAP1));

    // Hold cmd_valid for the whole table: ready must drop, nothing lost or reordered
    saw_not_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(vecs[i]);
    chk("ready_dropped", {15'd0, saw_not_ready}, 16'h0001);
    drain("full_drain");

    // Random commands with random idle spacing
    for (int i = 0; i < 10; i++) begin
      r.c   = 2'($urandom_range(0, 3));
      r.x   = 3'($urandom_range(0, 7));
      r.y   = 3'($urandom_range(0, 7));
      r.hdr = {1'b1, r.c, r.x, 2'b00};
      r.yb  = {3'b000, r.y, 2'b00};
      send(r);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain("random_drain");

    // GAP_CYCLES = 3 instance: exact byte sequence of two back-to-back frames
    fork
      begin
        send2(2'd2, 3'd5, 3'd3);
        send2(2'd1, 3'd7, 3'd7);
      end
      begin
        t = 0;
        while (!byte_valid2 && t < 20) begin
          @(negedge clk);
          t++;
        end
        if (!byte_valid2) begin
          fail_msg("gap3_no_header");
        end else begin
          for (int i = 0; i < 12; i++) begin
            chk("gap3_byte", {7'd0, byte_valid2, byte_out2}, {7'd0, g_v[i], g_b[i]});
            @(negedge clk);
          end
        end
      end
    join
    chk("gap3_idle_busy", {15'd0, busy2}, 16'h0000);

    // Reset during the Y byte with commands still pending
    for (int i = 0; i < N_RST; i++) send(vecs[i + 2]);
    t = 0;
    while (!(byte_valid && !byte_out[7]) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!(byte_valid && !byte_out[7])) fail_msg("rst_no_ybyte");
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {5'd0, cmd_ready, busy, byte_valid, byte_out}, {5'd0, 1'b1, 1'b0, 1'b0, 8'h00});
    exp_q.delete();
    phase_y  = 1'b0;
    gap_seen = 100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", {7'd0, busy, byte_out}, 16'h0000);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
